// File: rtl/foo_pkg.sv
// Shared types and constants for the sum accumulator and its result FIFO.
package foo_pkg;
  localparam int RES_TOTAL_W   = 64;
  localparam int RES_COUNT_W   = 8;
  localparam int BURST_LEN_DEF = 4;

  typedef struct packed {
    logic [RES_TOTAL_W-1:0] total;
    logic [RES_COUNT_W-1:0] count;
  } foo_res_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } foo_state_t;
endpackage

// File: rtl/foo_res_fifo.sv
// Two-entry result FIFO; a push into a full FIFO succeeds only alongside a pop.
module foo_res_fifo
  import foo_pkg::*;
#(
  parameter type T = foo_res_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  T     din,
  output logic full,
  output logic empty,
  output T     head
);
  T           r_mem [2];
  logic       r_rd;
  logic [1:0] r_cnt;

  logic w_pop;
  logic w_push;
  logic w_wr;

  assign full   = (r_cnt == 2'd2);
  assign empty  = (r_cnt == 2'd0);
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  // Write slot is rd+cnt mod 2; when full it is the head slot being popped.
  assign w_wr   = r_rd ^ r_cnt[0];
  assign head   = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_mem[w_wr] <= din;
      if (w_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end
endmodule

// File: rtl/foo_sum_accum.sv
// Accumulates upstream sums into bursts and queues {total, count} results
// for a valid/ready consumer; a result pushed into a full, non-draining FIFO is dropped.
module foo_sum_accum
  import foo_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int SUM_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sum_valid,
  input  logic [SUM_W-1:0]       sum,
  input  logic                   flush,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [RES_TOTAL_W-1:0] res_total,
  output logic [RES_COUNT_W-1:0] res_count,
  output logic                   overflow,
  output foo_state_t             dbg_state
);
  // Handshake: a result transfers on any cycle with res_valid && res_ready;
  // while res_valid is high and res_ready low, res_total/res_count hold.

  logic [RES_TOTAL_W-1:0] r_acc;
  logic [RES_COUNT_W-1:0] r_cnt;
  logic                   r_overflow;

  logic [RES_TOTAL_W-1:0] w_acc_next;
  logic [RES_COUNT_W-1:0] w_cnt_next;
  logic                   w_done;
  foo_state_t             w_state;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  foo_res_t               w_head;
  foo_res_t               w_push_res;

  always_comb begin
    w_acc_next = r_acc;
    w_cnt_next = r_cnt;
    w_state    = (r_cnt == '0) ? ST_IDLE : ST_ACCUM;
    if (sum_valid) begin
      w_acc_next = r_acc + RES_TOTAL_W'(sum);
      w_cnt_next = r_cnt + 1'b1;
    end
    // cnt_next != 0 covers both "partial burst open" and "sum arriving now".
    w_done = (sum_valid && (w_cnt_next == RES_COUNT_W'(BURST_LEN)))
          || (flush && (w_cnt_next != '0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_done) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
      end
      if (w_done && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign w_push_res = '{total: w_acc_next, count: w_cnt_next};
  assign w_pop      = !w_empty && res_ready;

  foo_res_fifo #(.T(foo_res_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_done),
    .pop   (w_pop),
    .din   (w_push_res),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign res_valid = !w_empty;
  assign res_total = w_empty ? '0 : w_head.total;
  assign res_count = w_empty ? '0 : w_head.count;
  assign overflow  = r_overflow;
  assign dbg_state = w_state;
endmodule

// File: tb/tb_foo_sum_accum.sv
// Bench for foo_sum_accum: directed burst scenarios plus random traffic against a queue-based model.
module tb_foo_sum_accum;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sum_valid = 1'b0;
  logic [31:0] sum = '0;
  logic        flush = 1'b0;
  logic        res_ready = 1'b0;
  logic        res_valid;
  logic [63:0] res_total;
  logic [7:0]  res_count;
  logic        overflow;
  foo_pkg::foo_state_t dbg_state;

  foo_sum_accum #(.BURST_LEN(BL), .SUM_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sum_valid (sum_valid),
    .sum       (sum),
    .flush     (flush),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_total (res_total),
    .res_count (res_count),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: open burst as plain integers, queued results as {total, count}.
  logic [63:0] m_acc = '0;
  int          m_cnt = 0;
  bit          m_ovf = 1'b0;
  logic [71:0] exp_q[$];

  int total_n = 0;
  int bad_n   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, drive inputs, then advance the model at the rising edge.
  task automatic step(input bit rst, input bit sv, input logic [31:0] s, input bit fl, input bit rr);
    bit          has;
    bit          pop;
    bit          done;
    @(negedge clk);
    has = (exp_q.size() > 0);
    chk("res_valid", {63'd0, res_valid}, {63'd0, has});
    chk("res_total", res_total, has ? exp_q[0][71:8] : 64'd0);
    chk("res_count", {56'd0, res_count}, has ? {56'd0, exp_q[0][7:0]} : 64'd0);
    chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
    chk("state", {63'd0, dbg_state}, {63'd0, (m_cnt != 0)});
    rst_n     = ~rst;
    sum_valid = sv;
    sum       = s;
    flush     = fl;
    res_ready = rr;
    @(posedge clk);
    if (rst) begin
      m_acc = '0;
      m_cnt = 0;
      m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      pop = has && rr;
      if (sv) begin
        m_acc = m_acc + {32'd0, s};
        m_cnt = m_cnt + 1;
      end
      done = (sv && m_cnt == BL) || (fl && m_cnt > 0);
      if (pop) void'(exp_q.pop_front());
      if (done) begin
        if (exp_q.size() < 2) exp_q.push_back({m_acc, 8'(m_cnt)});
        else m_ovf = 1'b1;
        m_acc = '0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic idle(input bit rr);
    step(1'b0, 1'b0, 32'd0, 1'b0, rr);
  endtask

  initial begin
    bit          r_rst;
    bit          r_sv;
    bit          r_fl;
    bit          r_rr;
    logic [31:0] r_s;

    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'd7, 1'b1, 1'b1);
    idle(1'b1);

    // Full burst 1..4
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 32'(i), 1'b0, 1'b1);
    #1 chk("burst_total", res_total, 64'd10);
    chk("burst_count", {56'd0, res_count}, 64'd4);
    idle(1'b1);
    idle(1'b1);

    // Wide sums: no 32-bit wrap
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    #1 chk("wide_total", res_total, 64'h3_FFFF_FFFC);
    idle(1'b1);

    // Flush with a coincident sum, then a no-op flush
    step(1'b0, 1'b1, 32'd5, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'd7, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'd9, 1'b1, 1'b1);
    #1 chk("flush_total", res_total, 64'd21);
    chk("flush_count", {56'd0, res_count}, 64'd3);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    #1 chk("flush_noop", {63'd0, res_valid}, 64'd0);
    idle(1'b1);

    // Backpressure: third burst is dropped
    for (int i = 0; i < 3 * BL; i++) step(1'b0, 1'b1, 32'd1, 1'b0, 1'b0);
    #1 chk("bp_overflow", {63'd0, overflow}, 64'd1);
    chk("bp_total", res_total, 64'd4);
    idle(1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Full FIFO with a pop in the completing cycle
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2 * BL; i++) step(1'b0, 1'b1, 32'd1, 1'b0, 1'b0);
    for (int i = 0; i < BL - 1; i++) step(1'b0, 1'b1, 32'd3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'd3, 1'b0, 1'b1);
    #1 chk("simul_overflow", {63'd0, overflow}, 64'd0);
    idle(1'b0);
    idle(1'b1);
    #1 chk("simul_second", res_total, 64'd12);
    idle(1'b1);
    idle(1'b1);

    // Reset in the middle of a burst
    step(1'b0, 1'b1, 32'd1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'd1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'd1, 1'b1, 1'b1);
    #1 chk("rst_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_total", res_total, 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'd2, 1'b0, 1'b1);
    #1 chk("rst_burst_total", res_total, 64'd8);
    chk("rst_burst_count", {56'd0, res_count}, 64'd4);
    idle(1'b1);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      r_rst = ($urandom_range(0, 149) == 0);
      r_sv  = ($urandom_range(0, 3) != 0);
      r_s   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 100));
      r_fl  = ($urandom_range(0, 7) == 0);
      r_rr  = ($urandom_range(0, 2) != 0);
      step(r_rst, r_sv, r_s, r_fl, r_rr);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule

// File: doc/foo_sum_accum.md
FOO_SUM_ACCUM -- requirements
Module: foo_sum_accum

Interface
REQ-001 Parameter: BURST_LEN, default 4, number of sums per completed burst (legal 1..255).
REQ-002 Parameter: SUM_W, default 32, width of each incoming sum.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 sum_valid  input  1  sum is valid this cycle; upstream adder stage cannot stall, so there is no ready.
REQ-007 sum  input  SUM_W  unsigned sum from the upstream two-stage adder pipeline.
REQ-008 flush  input  1  close the current partial burst.
REQ-009 res_valid  output  1  head result available.
REQ-010 res_ready  input  1  downstream accepts head result.
REQ-011 res_total  output  64  burst total, zero-extended accumulation.
REQ-012 res_count  output  8  number of sums in the burst (1..BURST_LEN).
REQ-013 overflow  output  1  sticky: a completed burst was dropped.

Function
REQ-014 The block SHALL hold a 64-bit accumulator acc and an 8-bit counter cnt, with states IDLE (cnt==0) and ACCUM (cnt>0).
REQ-015 On sum_valid, acc SHALL become acc + zero_extend(sum) and cnt SHALL become cnt+1, with no saturation or wrap for legal BURST_LEN.
REQ-016 A burst SHALL complete when an accepted sum makes cnt reach BURST_LEN.
REQ-017 A burst SHALL also complete when flush is high and either cnt>0 or sum_valid is high.
REQ-018 When flush and sum_valid are high together, the sum SHALL be included before the burst closes.
REQ-019 flush with cnt==0 and sum_valid low SHALL be a no-op.
REQ-020 On completion, {acc_next, cnt_next} SHALL be pushed to a 2-entry result FIFO, and acc and cnt SHALL clear to 0 (return to IDLE) at the same edge.
REQ-021 Latency: a result completed by the inputs of cycle k SHALL be visible on res_* in cycle k+1 if the FIFO was empty.
REQ-022 Pop SHALL occur when res_valid && res_ready.
REQ-023 res_valid SHALL be low when the FIFO is empty.
REQ-024 res_total and res_count SHALL be 0 when the FIFO is empty, and SHALL be held stable while res_valid && !res_ready.
REQ-025 Results SHALL leave in completion order.
REQ-026 Push when full with a simultaneous pop SHALL succeed, and occupancy SHALL stay 2.
REQ-027 Push when full without a pop SHALL drop the result and set overflow; acc and cnt SHALL still clear.
REQ-028 overflow SHALL remain high until reset.

Reset
REQ-029 While rst_n is low at a clock edge: acc=0, cnt=0, FIFO empty, res_valid=0, res_total=0, res_count=0, overflow=0.
REQ-030 Reset SHALL override sum_valid, flush and res_ready in the same cycle.
REQ-031 A partial burst interrupted by reset SHALL be discarded without producing a result.

Structure
REQ-032 Shared package foo_pkg SHALL hold RES_TOTAL_W=64, RES_COUNT_W=8, the default BURST_LEN, and the typedef foo_res_t {total, count}.
REQ-033 The 2-entry result FIFO SHALL be a separate sub-module, foo_res_fifo (push, pop, full, empty, head), parameterised on foo_res_t.
REQ-034 The accumulator and FSM SHALL live in foo_sum_accum.

Verification
REQ-035 Full burst: sums 1,2,3,4 on consecutive cycles with res_ready=1 -> one result total=10, count=4, res_valid high exactly one cycle, the cycle after the 4th sum.
REQ-036 Wide sums: four sums of 0xFFFFFFFF -> total=0x3_FFFFFFFC, count=4 (no 32-bit wrap).
REQ-037 Flush: sums 5,7, then flush together with sum 9 -> total=21, count=3; a following flush alone with cnt==0 -> no result.
REQ-038 Backpressure: res_ready=0, three bursts of BURST_LEN=4 of sum 1 -> two results held with total=4 each and overflow=1 after the third completion; then res_ready=1 -> exactly two results pop, in order.
REQ-039 Full with simultaneous pop: FIFO full, res_ready=1 in the same cycle a burst completes -> no overflow, occupancy stays 2.
REQ-040 Reset mid-burst: sums 1,1, then rst_n=0 for one cycle, then sums 2,2,2,2 -> single result total=8, count=4; all outputs 0 during reset.
